book_add_arbiter: RTL and testbench
===================================

Name: book_add_arbiter

Overview:
- Shares the single order-book add-write port between NUM_LANES decoder/parser lanes.
- Each lane presents a decoded add order (order_id, price, quantity, side). The block round-robin arbitrates, packs the winner into a book_entry and holds it in one output register stage with a valid/ready handshake toward the order book.
- Sits between the parser lanes and the order-book insert logic.

Parameters:
- NUM_LANES, 2, number of requesting parser lanes (2..8).
- LANE_W, $clog2(NUM_LANES) (min 1), width of the granted-lane index.
- CNT_W, 32, width of the accepted-order counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lane_valid  in  NUM_LANES  per-lane request
- lane_ready  out  NUM_LANES  per-lane accept; a transfer occurs when valid&ready
- lane_order_id  in  NUM_LANES*16  per-lane order id, lane i at [16*i+:16]
- lane_price  in  NUM_LANES*16  per-lane price
- lane_quantity  in  NUM_LANES*8  per-lane quantity
- lane_side  in  NUM_LANES  per-lane order_type (1=buy, 0=sell)
- out_valid  out  1  output entry valid
- out_ready  in  1  order book accepts the entry
- out_entry  out  book_entry (32)  packed {price[15:0], order_id[7:0], quantity[7:0]}
- out_side  out  1  side of out_entry
- out_lane  out  LANE_W  lane that produced out_entry
- accepted_cnt  out  CNT_W  total lane transfers since reset

Behaviour:
- Reset values: out_valid=0; out_entry, out_side, out_lane = 0; accepted_cnt=0; RR pointer=0; lane_ready=0 while rst_n low.
- Async reset mid-transfer: the pending output entry is discarded and the next accept starts from lane 0.
- Output stage: load_en = !out_valid | out_ready (full-throughput pipeline).
- Grant is combinational from lane_valid and the RR pointer. It searches from ptr upward with wrap; the first valid lane wins.
- lane_ready[i] = load_en & grant[i]. At most one bit is set per cycle; no lane is readied without its valid.
- On transfer of lane g:
  - out_entry.price = lane_price[g]; out_entry.order_id = lane_order_id[g][7:0] (upper 8 bits dropped); out_entry.quantity = lane_quantity[g]; out_side = lane_side[g]; out_lane = g; out_valid=1 next cycle.
  - ptr <= (g+1) mod NUM_LANES.
  - accepted_cnt increments by 1 and wraps at 2^CNT_W.
- No valid lane while load_en: out_valid <= 0 if out_ready was high, else out_valid holds. ptr is unchanged.
- out_valid & !out_ready: out_entry, out_side and out_lane are held stable and all lane_ready are 0 (backpressure).
- Simultaneous out_ready and a new grant: the old entry leaves and the new entry loads in the same cycle, so there is no bubble.
- Latency: 1 cycle from lane transfer to out_valid. Sustained throughput is 1 entry/cycle.
- Fairness: with all lanes continuously valid, each lane is granted exactly once every NUM_LANES transfers.
- A lane must hold valid and data stable until ready. The block does not check this.

Optional Feature:
- Macro ORDER_ID_RANGE_CHECK_EN.
- Defined:
  - A granted order whose lane_order_id[15:8] != 0 is still accepted (lane_ready asserts) but dropped. out_valid is not set for it; ptr and accepted_cnt still advance.
  - Extra output port drop_cnt [15:0] counts drops, saturates at 16'hFFFF, resets to 0.
- Not defined: no range check; ids are truncated to [7:0] as above; the drop_cnt port does not exist.

Decomposition:
- Package hft_pkg holds:
  - PRICE_INDEX=15, ORDER_INDEX=7, QUANTITY_INDEX=7, PRICE_WIDTH=15, ID_WIDTH=15, QUANT_WIDTH=7.
  - typedef book_entry.
  - The decoder top and this block both import it.
- Sub-module rr_arbiter (params N; in req[N], ptr; out grant[N] one-hot, grant_idx) is pure combinational. It is instantiated once and reusable for other book ports.

Test Plan:
- Reset: rst_n=0 with lane_valid=2'b11 -> out_valid=0, lane_ready=0, accepted_cnt=0. Release rst_n; the first grant is lane 0.
- Single lane: lane1 valid, id=16'h0042, price=16'h1234, qty=8'h05, side=1, out_ready=1 -> next cycle out_valid=1, out_entry=32'h1234_42_05, out_side=1, out_lane=1, accepted_cnt=1.
- Round-robin: both lanes held valid for 6 cycles, out_ready=1 -> out_lane sequence 0,1,0,1,0,1; accepted_cnt=6; no bubbles.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_entry stable, lane_ready=2'b00. Raise out_ready -> the held entry leaves and a new entry loads the same cycle.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=1 -> out_valid=0 immediately. After release, the ptr=0 grant order resumes.
- ORDER_ID_RANGE_CHECK_EN: lane0 id=16'h0100 -> lane_ready[0]=1, out_valid stays 0, drop_cnt=1, accepted_cnt=1. Without the macro, the same stimulus -> out_entry.order_id=8'h00, out_valid=1.

Source files
------------

// File: rtl/hft_pkg.sv
// hft_pkg: shared order-book field widths and the packed book_entry.
package hft_pkg;
  localparam int PRICE_INDEX    = 15;
  localparam int ORDER_INDEX    = 7;
  localparam int QUANTITY_INDEX = 7;
  localparam int PRICE_WIDTH    = 15;
  localparam int ID_WIDTH       = 15;
  localparam int QUANT_WIDTH    = 7;
  typedef struct packed {
    logic [PRICE_INDEX:0]    price;
    logic [ORDER_INDEX:0]    order_id;
    logic [QUANTITY_INDEX:0] quantity;
  } book_entry;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);
  always_comb begin
    int j;
    logic found;
    j = 0;
    found = 1'b0;
    grant = '0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        grant_idx = W'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/book_add_arbiter.sv
// book_add_arbiter: round-robin share of the order-book add port across parser lanes.
// ORDER_ID_RANGE_CHECK_EN drops orders whose id does not fit 8 bits and adds drop_cnt.
module book_add_arbiter
  import hft_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_LANES-1:0]   lane_valid,
  output logic [NUM_LANES-1:0]   lane_ready,
  input  logic [NUM_LANES*16-1:0] lane_order_id,
  input  logic [NUM_LANES*16-1:0] lane_price,
  input  logic [NUM_LANES*8-1:0] lane_quantity,
  input  logic [NUM_LANES-1:0]   lane_side,
  output logic                   out_valid,
  input  logic                   out_ready,
  output book_entry              out_entry,
  output logic                   out_side,
  output logic [LANE_W-1:0]      out_lane,
`ifdef ORDER_ID_RANGE_CHECK_EN
  output logic [15:0]            drop_cnt,
`endif
  output logic [CNT_W-1:0]       accepted_cnt
);
  logic [NUM_LANES-1:0] grant;
  logic [LANE_W-1:0]    g;
  logic [LANE_W-1:0]    ptr;
  logic                 load_en;
  logic                 xfer;
  logic                 drop;
  logic [7:0]           id_hi;
  rr_arbiter #(.N(NUM_LANES), .W(LANE_W)) u_rr (
    .req(lane_valid),
    .ptr(ptr),
    .grant(grant),
    .grant_idx(g)
  );
  always_comb begin
    load_en = !out_valid | out_ready;
    lane_ready = (load_en & rst_n) ? grant : '0;
    xfer = |lane_ready;
    id_hi = lane_order_id[{g, 4'd8} +: 8];
  end
`ifdef ORDER_ID_RANGE_CHECK_EN
  assign drop = |id_hi;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (xfer && drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
`else
  logic unused_id_hi;
  assign drop = 1'b0;
  assign unused_id_hi = ^id_hi;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_entry <= '0;
      out_side <= 1'b0;
      out_lane <= '0;
      ptr <= '0;
      accepted_cnt <= '0;
    end else if (xfer) begin
      out_valid <= !drop;
      out_entry.price <= lane_price[{g, 4'd0} +: 16];
      out_entry.order_id <= lane_order_id[{g, 4'd0} +: 8];
      out_entry.quantity <= lane_quantity[{g, 3'd0} +: 8];
      out_side <= lane_side[g];
      out_lane <= g;
      ptr <= (g == LANE_W'(NUM_LANES - 1)) ? '0 : g + 1'b1;
      accepted_cnt <= accepted_cnt + 1'b1;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_book_add_arbiter.sv
// tb_book_add_arbiter: directed vectors for the two-lane add-port arbiter.
module tb_book_add_arbiter;
  import hft_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  lane_valid;
  logic [1:0]  lane_ready;
  logic [31:0] lane_order_id;
  logic [31:0] lane_price;
  logic [15:0] lane_quantity;
  logic [1:0]  lane_side;
  logic        out_valid;
  logic        out_ready;
  book_entry   out_entry;
  logic        out_side;
  logic [0:0]  out_lane;
  logic [31:0] accepted_cnt;
`ifdef ORDER_ID_RANGE_CHECK_EN
  logic [15:0] drop_cnt;
`endif
  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_cnt = 0;
  book_add_arbiter #(.NUM_LANES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lane_valid(lane_valid),
    .lane_ready(lane_ready),
    .lane_order_id(lane_order_id),
    .lane_price(lane_price),
    .lane_quantity(lane_quantity),
    .lane_side(lane_side),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_entry(out_entry),
    .out_side(out_side),
    .out_lane(out_lane),
`ifdef ORDER_ID_RANGE_CHECK_EN
    .drop_cnt(drop_cnt),
`endif
    .accepted_cnt(accepted_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    lane_valid = 2'b11;
    lane_order_id = {16'h0042, 16'h0011};
    lane_price = {16'h1234, 16'hAAAA};
    lane_quantity = {8'h05, 8'h01};
    lane_side = 2'b10;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_lane_ready", lane_ready, 0);
    check("rst_cnt", accepted_cnt, 0);
    check("rst_entry", out_entry, 0);
    rst_n = 1'b1;
    #1;
    check("first_grant_ready", lane_ready, 2'b01);
    tick();
    exp_cnt++;
    check("first_lane", out_lane, 0);
    check("first_entry", out_entry, 32'hAAAA_11_01);
    check("first_cnt", accepted_cnt, exp_cnt);
    lane_valid = 2'b10;
    #1;
    check("single_ready", lane_ready, 2'b10);
    tick();
    exp_cnt++;
    check("single_valid", out_valid, 1);
    check("single_entry", out_entry, 32'h1234_42_05);
    check("single_side", out_side, 1);
    check("single_lane", out_lane, 1);
    check("single_cnt", accepted_cnt, exp_cnt);
    lane_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_cnt++;
      check("rr_valid", out_valid, 1);
      check("rr_lane", out_lane, i % 2);
    end
    check("rr_cnt", accepted_cnt, exp_cnt);
    out_ready = 1'b0;
    #1;
    check("bp_ready", lane_ready, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_entry", out_entry, 32'h1234_42_05);
      check("bp_lane", out_lane, 1);
      check("bp_ready_hold", lane_ready, 2'b00);
    end
    check("bp_cnt", accepted_cnt, exp_cnt);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", lane_ready, 2'b01);
    tick();
    exp_cnt++;
    check("bp_release_valid", out_valid, 1);
    check("bp_release_entry", out_entry, 32'hAAAA_11_01);
    check("bp_release_cnt", accepted_cnt, exp_cnt);
    lane_valid = 2'b00;
    #1;
    check("idle_ready", lane_ready, 2'b00);
    tick();
    check("idle_valid", out_valid, 0);
    check("idle_cnt", accepted_cnt, exp_cnt);
    lane_valid = 2'b11;
    tick();
    check("pre_arst_lane", out_lane, 1);
    check("pre_arst_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_cnt", accepted_cnt, 0);
    check("arst_ready", lane_ready, 2'b00);
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_cnt++;
    check("arst_resume_lane0", out_lane, 0);
    tick();
    exp_cnt++;
    check("arst_resume_lane1", out_lane, 1);
    check("arst_resume_cnt", accepted_cnt, exp_cnt);
    lane_valid = 2'b01;
    lane_order_id = {16'h0042, 16'h0100};
    #1;
    check("range_ready", lane_ready, 2'b01);
    tick();
    exp_cnt++;
    check("range_cnt", accepted_cnt, exp_cnt);
`ifdef ORDER_ID_RANGE_CHECK_EN
    check("range_dropped_valid", out_valid, 0);
    check("range_drop_cnt", drop_cnt, 1);
`else
    check("range_trunc_valid", out_valid, 1);
    check("range_trunc_entry", out_entry, 32'hAAAA_00_01);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
